if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 32-bit MIPS pipeline. It holds the program counter, reads the word-addressed instruction memory, and drives the instruction and PC+4 that the IF/ID pipeline register captures on every clock edge. It accepts stall from hazard detection and redirects from jump (ID) and branch (EX) resolution. It also provides a program-load write port and fetch bookkeeping.

Parameters:
IMEM_DEPTH, 256, number of 32-bit words in instruction memory (power of two, 16..4096)
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_WORD, 32'h0000_0000, instruction emitted on squash or out-of-range fetch

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  hold PC; re-present the same instruction
jump_taken  input  1  jump resolved in ID this cycle
jump_target  input  32  jump destination byte address
branch_taken  input  1  branch resolved in EX this cycle
branch_target  input  32  branch destination byte address
imem_we  input  1  program-load write enable
imem_waddr  input  log2(IMEM_DEPTH)  program-load word address
imem_wdata  input  32  program-load data
instruction_memory  output  32  fetched instruction, to IF/ID
pc_next  output  32  pc_current + 4, to IF/ID
pc_current  output  32  address of the word being fetched
fetch_count  output  32  number of instructions issued
misalign_err  output  1  sticky flag for a misaligned redirect target

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc_current = RESET_PC
  - pc_next = RESET_PC + 4
  - fetch_count = 0
  - misalign_err = 0
  - instruction memory contents are NOT cleared.
- The PC register updates on the rising edge. Priority, highest first:
  1. rst: PC <= RESET_PC
  2. branch_taken: PC <= {branch_target[31:2], 2'b00}
  3. jump_taken: PC <= {jump_target[31:2], 2'b00}
  4. stall: PC holds
  5. otherwise: PC <= PC + 4
- Branch beats jump because the branch belongs to the older instruction.
- A redirect overrides stall.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. pc_next follows the same wrap.
- Fetch read is combinational from pc_current, with word index pc_current[log2(IMEM_DEPTH)+1:2].
- If pc_current >= 4*IMEM_DEPTH, instruction_memory = NOP_WORD. There is no aliasing.
- Squash: in any cycle where branch_taken or jump_taken is 1, instruction_memory = NOP_WORD. The wrong-path fetch becomes a bubble in IF/ID, since IF/ID has no flush input.
- Stall without redirect:
  - PC holds, and the same instruction and pc_next are re-presented.
  - IF/ID re-captures identical values, which yields a repeat, not a bubble.
- fetch_count increments by 1 on each edge where rst=0, stall=0, branch_taken=0 and jump_taken=0. It wraps at 2^32.
- misalign_err is set on an edge where the selected redirect target has bits [1:0] != 0. It stays set until rst. The target is still aligned and taken.
- Program load:
  - Synchronous write on the rising edge when imem_we=1.
  - A read of the same word in the write cycle returns the old data. The new data is visible from the next cycle.
  - Writes are independent of stall and redirect.
  - rst does not block writes.
- Reset mid-operation: the pending redirect and stall are ignored, and the PC returns to RESET_PC on that edge.
- Outputs have no X after the first reset edge. Unwritten memory locations read as NOP_WORD (the array is initialised to NOP_WORD).
- Implementation is pure RTL with a single always block per register group. The memory must infer distributed RAM.

Test Plan:
1. Load words 0..3 = 32'h2008_0001, 32'h2009_0002, 32'h010A_5020, 32'h0000_0000, then release rst → pc_current 0, 4, 8, 12 on successive cycles. instruction_memory matches each word. pc_next = 4, 8, 12, 16. fetch_count = 4 after 4 edges.
2. Assert stall for 3 cycles at PC=8 → pc_current stays 8, instruction_memory stays 32'h010A_5020 and fetch_count stays frozen. Deassert stall → PC becomes 12.
3. Assert branch_taken (target 32'h40) and jump_taken (target 32'h80) in the same cycle at PC=4 → instruction_memory = 0 that cycle, next pc_current = 32'h40, fetch_count unchanged.
4. Assert jump_taken with target 32'h0000_0012 together with stall=1 → next PC = 32'h10 and misalign_err = 1, which persists until rst.
5. Redirect to 32'hFFFF_FFFC → instruction_memory = NOP_WORD (out of range), pc_next = 0. The next PC is 0 and the fetch returns word 0.
6. Assert rst while branch_taken=1 and imem_we=1 (addr 5, data 32'hDEAD_BEEF) → PC = RESET_PC, fetch_count = 0, and word 5 reads 32'hDEAD_BEEF afterward.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction RAM with a
// program-load port, squash on redirect, and fetch bookkeeping for IF/ID.
module if_fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          jump_taken,
  input  logic [31:0]                   jump_target,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instruction_memory,
  output logic [31:0]                   pc_next,
  output logic [31:0]                   pc_current,
  output logic [31:0]                   fetch_count,
  output logic                          misalign_err
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0]   mem [IMEM_DEPTH] = '{default: NOP_WORD};
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          redirect;
  logic [31:0]   redirect_target;

  assign word_idx = pc_current[AW+1:2];
  assign in_range = (pc_current[31:AW+2] == '0);
  assign redirect = branch_taken | jump_taken;
  // Branch is the older instruction, so its target wins over a same-cycle jump.
  assign redirect_target = branch_taken ? branch_target : jump_target;

  assign pc_next = pc_current + 32'd4;

  // A redirect cycle's fetch is wrong-path; emit a bubble since IF/ID cannot flush.
  always_comb begin
    instruction_memory = NOP_WORD;
    if (!redirect && in_range) begin
      instruction_memory = mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_current <= RESET_PC;
    end else if (redirect) begin
      pc_current <= {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_current <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (!redirect && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed plan steps then random traffic, each step
// compared against a word-level model of the fetch stage.
module tb_if_fetch_stage;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned AW         = $clog2(IMEM_DEPTH);
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          jump_taken = 1'b0;
  logic [31:0]   jump_target = '0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_target = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic [31:0]   instruction_memory;
  logic [31:0]   pc_next;
  logic [31:0]   pc_current;
  logic [31:0]   fetch_count;
  logic          misalign_err;

  if_fetch_stage #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .RESET_PC  (RESET_PC),
    .NOP_WORD  (NOP_WORD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .jump_taken        (jump_taken),
    .jump_target       (jump_target),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_we           (imem_we),
    .imem_waddr        (imem_waddr),
    .imem_wdata        (imem_wdata),
    .instruction_memory(instruction_memory),
    .pc_next           (pc_next),
    .pc_current        (pc_current),
    .fetch_count       (fetch_count),
    .misalign_err      (misalign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: architectural PC, issue count, sticky error, memory image.
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_mis;
  logic [31:0] m_mem [IMEM_DEPTH];
  bit          model_valid = 0;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic squash);
    logic [31:0] exp_instr;
    if (squash || m_pc >= 32'(4 * IMEM_DEPTH)) exp_instr = NOP_WORD;
    else exp_instr = m_mem[int'(m_pc / 4)];
    checkOne({tag, ".pc_current"}, pc_current, m_pc);
    checkOne({tag, ".pc_next"}, pc_next, m_pc + 32'd4);
    checkOne({tag, ".instruction"}, instruction_memory, exp_instr);
    checkOne({tag, ".fetch_count"}, fetch_count, m_count);
    checkOne({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, m_mis});
  endtask

  task automatic applyStimulus(input logic r, input logic s,
                               input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic we, input logic [AW-1:0] wa,
                               input logic [31:0] wd, input string tag);
    logic [31:0] tgt;
    rst = r; stall = s;
    branch_taken = b; branch_target = bt;
    jump_taken = j; jump_target = jt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    #1;
    if (model_valid) checkOutput(tag, b | j);
    @(posedge clk);
    if (we) m_mem[wa] = wd;
    tgt = b ? bt : jt;
    if (r) begin
      m_pc = RESET_PC; m_count = 0; m_mis = 0;
    end else if (b || j) begin
      m_pc = tgt - (tgt % 4);
      if (tgt % 4 != 0) m_mis = 1;
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
    model_valid = 1;
    #1;
  endtask

  task automatic plainSteps(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < int'(IMEM_DEPTH); i++) m_mem[i] = NOP_WORD;
    m_pc = RESET_PC; m_count = 0; m_mis = 0;

    // Program load during reset, then free-running fetch.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 32'h2008_0001, "load0");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'h2009_0002, "load1");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 2, 32'h010A_5020, "load2");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 3, 32'h0000_0000, "load3");
    plainSteps(4, "seq");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "seq_after4");

    // Stall at PC=8 for three cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_a");
    plainSteps(2, "pre_stall");
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, "stall");
    plainSteps(2, "post_stall");

    // Simultaneous branch and jump at PC=4: branch wins, fetch squashed.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_b");
    plainSteps(1, "pre_redirect");
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h80, 0, 0, 0, "br_and_jmp");
    plainSteps(1, "at_0x40");

    // Misaligned jump overriding stall.
    applyStimulus(0, 1, 0, 0, 1, 32'h0000_0012, 0, 0, 0, "jmp_misalign");
    plainSteps(3, "sticky_mis");

    // Same-cycle write and read of one word returns the old data.
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, "to_0x10");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 32'h1234_5678, "wr_same_word");
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 0, 0, 0, "back_0x10");
    plainSteps(1, "read_new_word");

    // Top-of-address-space wrap.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, "to_top");
    plainSteps(2, "wrap");

    // Reset beats a redirect but not a write.
    applyStimulus(1, 0, 1, 32'h100, 0, 0, 1, 5, 32'hDEAD_BEEF, "rst_br_we");
    plainSteps(6, "read_word5");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] bt, jt;
      bt = $urandom & 32'h0000_07FF;
      jt = $urandom & 32'h0000_07FF;
      if ($urandom_range(0, 19) == 0) bt = 32'hFFFF_FFFC;
      applyStimulus(logic'($urandom_range(0, 49) == 0),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 9) == 0), bt,
                    logic'($urandom_range(0, 9) == 0), jt,
                    logic'($urandom_range(0, 3) == 0),
                    AW'($urandom_range(0, IMEM_DEPTH - 1)), $urandom,
                    "random");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
